// File: rtl/wptr_stream_ctrl.sv
// Write-side front end of the async FIFO: valid/ready intake through a 2-entry skid buffer,
// write strobes gated by wr_full, and a pessimistic write-domain fill level / almost-full flag.
module wptr_stream_ctrl #(
   parameter int unsigned ASIZE        = 4,
   parameter int unsigned DSIZE        = 8,
   parameter int unsigned AFULL_THRESH = 2**ASIZE - 2
) (
   input  logic               wr_clk,
   input  logic               wr_rst_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DSIZE-1:0]   s_data,
   input  logic               wr_full,
   input  logic [ASIZE:0]     wr_ptr,
   input  logic [ASIZE:0]     r2w_ptr,
   output logic               wr_inc,
   output logic [DSIZE-1:0]   wr_data,
   output logic [ASIZE:0]     wr_level,
   output logic               wr_almost_full
);

   localparam int unsigned PTR_W = ASIZE + 1;
   localparam logic [PTR_W-1:0] AFULL_T = PTR_W'(AFULL_THRESH);

   // ST_OUT: only the out register holds a word; ST_FULL: out and skid both hold words
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_OUT   = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_t;

   buf_state_t       r_state;
   buf_state_t       w_state_nxt;
   logic [DSIZE-1:0] r_out;
   logic [DSIZE-1:0] r_skid;
   logic             r_s_ready;
   logic [PTR_W-1:0] r_level;
   logic             r_afull;

   logic             w_out_valid;
   logic             w_pop;
   logic             w_accept;
   logic             w_load_out_s;
   logic             w_load_out_skid;
   logic             w_load_skid;
   logic [PTR_W-1:0] w_wbin;
   logic [PTR_W-1:0] w_rbin;
   logic [PTR_W-1:0] w_diff;

   function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
      logic [PTR_W-1:0] b;
      b[PTR_W-1] = g[PTR_W-1];
      for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_pop       = w_out_valid & ~wr_full;
   assign w_accept    = s_valid & r_s_ready;

   // Buffer next-state and load selects
   always_comb begin
      w_state_nxt     = r_state;
      w_load_out_s    = 1'b0;
      w_load_out_skid = 1'b0;
      w_load_skid     = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_load_out_s = 1'b1;
               w_state_nxt  = ST_OUT;
            end
         end
         ST_OUT: begin
            if (w_pop) begin
               if (w_accept) begin
                  w_load_out_s = 1'b1;
               end else begin
                  w_state_nxt = ST_EMPTY;
               end
            end else if (w_accept) begin
               w_load_skid = 1'b1;
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (w_pop) begin
               w_load_out_skid = 1'b1;
               w_state_nxt     = ST_OUT;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // s_ready follows the next skid occupancy so a filling skid closes intake on the same edge
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         r_state   <= ST_EMPTY;
         r_out     <= '0;
         r_skid    <= '0;
         r_s_ready <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_s_ready <= (w_state_nxt != ST_FULL);
         if (w_load_out_s) begin
            r_out <= s_data;
         end else if (w_load_out_skid) begin
            r_out <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= s_data;
         end
      end
   end

   assign w_wbin = gray2bin(wr_ptr);
   assign w_rbin = gray2bin(r2w_ptr);
   assign w_diff = w_wbin - w_rbin;

   // Occupancy from pointers only; the modular subtract absorbs pointer wrap
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         r_level <= '0;
         r_afull <= 1'b0;
      end else begin
         r_level <= w_diff;
         r_afull <= (w_diff >= AFULL_T);
      end
   end

   assign s_ready        = r_s_ready;
   assign wr_inc         = w_pop;
   assign wr_data        = r_out;
   assign wr_level       = r_level;
   assign wr_almost_full = r_afull;

endmodule

// File: tb/tb_wptr_stream_ctrl.sv
// Directed bench for wptr_stream_ctrl with a small write-pointer/full model and an in-order pop checker.
module tb_wptr_stream_ctrl;

   localparam int unsigned ASIZE = 4;
   localparam int unsigned DSIZE = 8;

   logic             clk;
   logic             rst_n;
   logic             s_valid;
   logic             s_ready;
   logic [DSIZE-1:0] s_data;
   logic             wr_full;
   logic [ASIZE:0]   wr_ptr;
   logic [ASIZE:0]   r2w_ptr;
   logic             wr_inc;
   logic [DSIZE-1:0] wr_data;
   logic [ASIZE:0]   wr_level;
   logic             wr_almost_full;

   logic             ovr;
   logic             ovr_full;
   logic [ASIZE:0]   ovr_wptr;
   logic [ASIZE:0]   wbin;
   logic             acc_q;
   logic [DSIZE-1:0] exp_next;
   int               n_pulse;
   int               n_checks;
   int               n_errors;

   wptr_stream_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AFULL_THRESH(14)) dut (
      .wr_clk(clk), .wr_rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .wr_full(wr_full), .wr_ptr(wr_ptr), .r2w_ptr(r2w_ptr), .wr_inc(wr_inc), .wr_data(wr_data),
      .wr_level(wr_level), .wr_almost_full(wr_almost_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [ASIZE:0] g2b(input logic [ASIZE:0] g);
      logic [ASIZE:0] b;
      b = g;
      for (int k = 1; k <= int'(ASIZE); k++) b = b ^ (g >> k);
      return b;
   endfunction

   // Pointer-block model: binary write count, gray output, full when 16 ahead of the read pointer
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wbin <= '0;
      else if (wr_inc) wbin <= wbin + 5'd1;
   end

   always_comb begin
      if (ovr) begin
         wr_ptr  = ovr_wptr;
         wr_full = ovr_full;
      end else begin
         wr_ptr  = wbin ^ (wbin >> 1);
         wr_full = !rst_n || (5'(wbin - g2b(r2w_ptr)) == 5'd16);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Mid-cycle sampling of handshakes and write strobes
   always @(negedge clk) begin
      if (!rst_n) begin
         acc_q = 1'b0;
      end else begin
         acc_q = s_valid & s_ready;
         if (wr_inc) begin
            n_pulse++;
            chk("pop_data", 32'(wr_data), 32'(exp_next));
            exp_next = exp_next + 8'd1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_src(input logic [DSIZE-1:0] last);
      tick();
      if (acc_q) begin
         if (s_data == last) s_valid = 1'b0;
         else s_data = s_data + 8'd1;
      end
   endtask

   int             base;
   int             cyc;
   logic           done;

   initial begin
      n_checks = 0; n_errors = 0; n_pulse = 0;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; r2w_ptr = '0;
      ovr = 1'b0; ovr_full = 1'b0; ovr_wptr = '0; exp_next = 8'h00; acc_q = 1'b0;

      // 1: reset values, then s_ready rises on the first edge after release
      #12;
      chk("rst_inc", 32'(wr_inc), 0);
      chk("rst_ready", 32'(s_ready), 0);
      chk("rst_level", 32'(wr_level), 0);
      chk("rst_afull", 32'(wr_almost_full), 0);
      chk("rst_data", 32'(wr_data), 0);
      #10;
      rst_n = 1'b1; s_valid = 1'b1; s_data = 8'h00;
      #1;
      chk("pre_edge_ready", 32'(s_ready), 0);
      tick_src(8'h11);
      chk("first_edge_ready", 32'(s_ready), 1);
      chk("first_edge_inc", 32'(wr_inc), 0);

      // 2: 16 back-to-back writes, then full holds 0x10 in out and 0x11 in skid
      tick_src(8'h11);
      for (int i = 0; i < 16; i++) begin
         chk("burst_inc", 32'(wr_inc), 1);
         chk("burst_data", 32'(wr_data), 32'(i));
         tick_src(8'h11);
      end
      tick_src(8'h11);
      chk("full_inc", 32'(wr_inc), 0);
      chk("full_out", 32'(wr_data), 32'h10);
      chk("full_ready", 32'(s_ready), 0);
      chk("full_valid_done", 32'(s_valid), 0);
      chk("full_pulses", 32'(n_pulse), 16);
      chk("full_level", 32'(wr_level), 16);
      chk("full_afull", 32'(wr_almost_full), 1);
      tick();
      chk("full_hold_inc", 32'(wr_inc), 0);
      chk("full_hold_out", 32'(wr_data), 32'h10);
      r2w_ptr = 5'h18;
      #1;
      chk("drain0_inc", 32'(wr_inc), 1);
      chk("drain0_data", 32'(wr_data), 32'h10);
      tick();
      chk("drain1_inc", 32'(wr_inc), 1);
      chk("drain1_data", 32'(wr_data), 32'h11);
      chk("drain1_ready", 32'(s_ready), 1);
      tick();
      chk("drain_empty", 32'(wr_inc), 0);
      chk("drain_pulses", 32'(n_pulse), 18);
      chk("drain_exp", 32'(exp_next), 32'h12);

      // 3/4: level and almost-full from gray pointers, including wrap
      ovr = 1'b1; ovr_full = 1'b0; ovr_wptr = 5'h09; r2w_ptr = 5'h00;
      tick();
      chk("lvl14", 32'(wr_level), 14);
      chk("lvl14_afull", 32'(wr_almost_full), 1);
      r2w_ptr = 5'h07;
      #1;
      chk("lvl_stale", 32'(wr_level), 14);
      tick();
      chk("lvl9", 32'(wr_level), 9);
      chk("lvl9_afull", 32'(wr_almost_full), 0);
      ovr_wptr = 5'h02; r2w_ptr = 5'h13;
      tick();
      chk("lvl_wrap", 32'(wr_level), 6);
      chk("lvl_wrap_afull", 32'(wr_almost_full), 0);

      // 5: toggling full with random valid, 64 words in order
      base = n_pulse; exp_next = 8'h20; s_data = 8'h20; s_valid = 1'b0; done = 1'b0;
      cyc = 0;
      while ((n_pulse - base) < 64 && cyc < 2000) begin
         tick();
         cyc++;
         ovr_full = ~ovr_full;
         if (acc_q) begin
            if (s_data == 8'h5F) begin
               done = 1'b1; s_valid = 1'b0;
            end else begin
               s_data = s_data + 8'd1;
            end
         end
         if (!done && (!s_valid || acc_q)) s_valid = 1'($urandom_range(0, 1));
      end
      chk("tog_timeout", 32'(cyc < 2000), 1);
      repeat (4) begin
         tick();
         ovr_full = ~ovr_full;
      end
      chk("tog_pulses", 32'(n_pulse - base), 64);
      chk("tog_exp", 32'(exp_next), 32'h60);

      // 6: reset with skid full discards both words
      ovr_full = 1'b1; ovr_wptr = 5'h09; r2w_ptr = 5'h00;
      s_valid = 1'b1; s_data = 8'h70; exp_next = 8'h70;
      tick_src(8'h7F);
      tick_src(8'h7F);
      tick_src(8'h7F);
      chk("pre_rst_ready", 32'(s_ready), 0);
      chk("pre_rst_out", 32'(wr_data), 32'h70);
      chk("pre_rst_level", 32'(wr_level), 14);
      #1;
      rst_n = 1'b0; ovr_full = 1'b0;
      #1;
      chk("mid_rst_inc", 32'(wr_inc), 0);
      chk("mid_rst_ready", 32'(s_ready), 0);
      chk("mid_rst_level", 32'(wr_level), 0);
      chk("mid_rst_afull", 32'(wr_almost_full), 0);
      s_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      base = n_pulse;
      repeat (6) tick();
      chk("post_rst_pulses", 32'(n_pulse - base), 0);
      chk("post_rst_ready", 32'(s_ready), 1);
      chk("post_rst_level", 32'(wr_level), 14);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
